sm_hex_display_scan: RTL and testbench

SM_HEX_DISPLAY_SCAN -- requirements
Module: sm_hex_display_scan

---
 rtl/sm_hex_display_scan.sv | 153 +++++++++++++++
 tb/tb_sm_hex_display_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sm_hex_display_scan.sv
// Time-multiplexed hex seven-segment scanner; each frame shows a snapshot of number/dp.
// Optional leading-zero blanking is enabled by defining SM_HEX_DISPLAY_SCAN_LZ_BLANK_EN.
module sm_hex_display_scan #(
  parameter int unsigned DIGIT_COUNT    = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*DIGIT_COUNT-1:0] number,
  input  logic [DIGIT_COUNT-1:0]   dp,
  input  logic                     enable,
  output logic [6:0]               seven_segments,
  output logic                     dot,
  output logic [DIGIT_COUNT-1:0]   anodes,
  output logic                     frame_start
);

  localparam int unsigned IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0]             SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                   DOT_OFF = SEG_ACTIVE_LOW;
  localparam logic [DIGIT_COUNT-1:0] AN_OFF  = {DIGIT_COUNT{AN_ACTIVE_LOW}};
  localparam logic [PRE_W-1:0]       PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]       IDX_MAX = IDX_W'(DIGIT_COUNT - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h67;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [PRE_W-1:0]         prescaler_q, prescaler_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [4*DIGIT_COUNT-1:0] snap_num_q, snap_num_d;
  logic [DIGIT_COUNT-1:0]   snap_dp_q, snap_dp_d;
  logic                     frame_start_q, frame_start_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dot_q, dot_d;
  logic [DIGIT_COUNT-1:0]   an_q, an_d;

  logic                     tick_s;
  logic [3:0]               nibble_s;
  logic                     blank_s;

  assign tick_s   = enable && (prescaler_q == PRE_MAX);
  assign nibble_s = snap_num_q[{idx_q, 2'b00} +: 4];

`ifdef SM_HEX_DISPLAY_SCAN_LZ_BLANK_EN
  logic [DIGIT_COUNT-1:0] lead_zero_s;

  // Digit k is a leading zero when every snapshot nibble from the top down to k is zero.
  always_comb begin : lz_scan
    logic all_zero;
    all_zero    = 1'b1;
    lead_zero_s = '0;
    for (int k = DIGIT_COUNT - 1; k >= 1; k--) begin
      all_zero       = all_zero && (snap_num_q[4*k +: 4] == 4'h0);
      lead_zero_s[k] = all_zero;
    end
  end

  assign blank_s = lead_zero_s[idx_q];
`else
  assign blank_s = 1'b0;
`endif

  // Next-state: prescaler/index advance, frame snapshot, and the blanked-or-decoded outputs.
  always_comb begin
    prescaler_d   = prescaler_q;
    idx_d         = idx_q;
    snap_num_d    = snap_num_q;
    snap_dp_d     = snap_dp_q;
    frame_start_d = 1'b0;
    seg_d         = SEG_OFF;
    dot_d         = DOT_OFF;
    an_d          = AN_OFF;
    if (enable) begin
      if (tick_s) begin
        prescaler_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d         = '0;
          snap_num_d    = number;
          snap_dp_d     = dp;
          frame_start_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        prescaler_d = prescaler_q + PRE_W'(1);
      end
      // Outputs describe the digit selected before this cycle's advance.
      if (blank_s) begin
        seg_d = SEG_OFF;
      end else begin
        seg_d = hex_to_seg(nibble_s) ^ {7{SEG_ACTIVE_LOW}};
      end
      dot_d = snap_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
      an_d  = (DIGIT_COUNT'(1'b1) << idx_q) ^ AN_OFF;
    end else begin
      frame_start_d = 1'b0;
    end
  end

  // State and output registers with asynchronous clear to the inactive display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q   <= '0;
      idx_q         <= '0;
      snap_num_q    <= '0;
      snap_dp_q     <= '0;
      frame_start_q <= 1'b0;
      seg_q         <= SEG_OFF;
      dot_q         <= DOT_OFF;
      an_q          <= AN_OFF;
    end else begin
      prescaler_q   <= prescaler_d;
      idx_q         <= idx_d;
      snap_num_q    <= snap_num_d;
      snap_dp_q     <= snap_dp_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      dot_q         <= dot_d;
      an_q          <= an_d;
    end
  end

  assign seven_segments = seg_q;
  assign dot            = dot_q;
  assign anodes         = an_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Bench for sm_hex_display_scan: table-driven frames via a scoreboard queue, plus
// hand sequences for reset, enable hold/resume and inverted polarity.
module tb_sm_hex_display_scan;

  localparam int NV = 6;
`ifdef SM_HEX_DISPLAY_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  dp;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dot;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] number;
  logic [3:0]  dp;
  logic        enable;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dot_a, dot_b, dot_c;
  logic [3:0] an_a, an_b, an_c;
  logic       fs_a, fs_b, fs_c;

  int   checks;
  int   errors;
  exp_t sb_q[$];
  vec_t vecs [NV];

  sm_hex_display_scan #(.DIGIT_COUNT(4), .SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .number(number), .dp(dp), .enable(enable),
    .seven_segments(seg_a), .dot(dot_a), .anodes(an_a), .frame_start(fs_a));

  sm_hex_display_scan #(.DIGIT_COUNT(4), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .number(number), .dp(dp), .enable(enable),
    .seven_segments(seg_b), .dot(dot_b), .anodes(an_b), .frame_start(fs_b));

  sm_hex_display_scan #(.DIGIT_COUNT(4), .SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .number(number), .dp(dp), .enable(enable),
    .seven_segments(seg_c), .dot(dot_c), .anodes(an_c), .frame_start(fs_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [27:0] segs, input logic [3:0] dps);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.an  = 4'b0001 << d;
      e.seg = segs[d*7 +: 7];
      e.dot = dps[d];
      sb_q.push_back(e);
    end
  endtask

  initial begin
    exp_t       e;
    logic [6:0] inv_seg;
    logic [3:0] inv_an;
    logic       inv_dot;
    logic [27:0] zero_segs;
    logic [3:0] b_run [5];
    logic [3:0] b_resume [5];
    logic [6:0] a_after_rst [3];

    checks = 0;
    errors = 0;
    zero_segs = LZ ? {7'h00, 7'h00, 7'h00, 7'h3F} : {4{7'h3F}};

    vecs[0] = '{num: 16'h1234, dp: 4'b0000, segs: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{num: 16'hABCD, dp: 4'b1010, segs: {7'h77, 7'h7C, 7'h39, 7'h5E}};
    vecs[2] = '{num: 16'h5678, dp: 4'b0001, segs: {7'h6D, 7'h7D, 7'h07, 7'h7F}};
    vecs[3] = '{num: 16'h90EF, dp: 4'b1111, segs: {7'h67, 7'h3F, 7'h79, 7'h71}};
    vecs[4] = '{num: 16'h0005, dp: 4'b0100,
                segs: LZ ? {7'h00, 7'h00, 7'h00, 7'h6D} : {7'h3F, 7'h3F, 7'h3F, 7'h6D}};
    vecs[5] = '{num: 16'h0000, dp: 4'b0000, segs: zero_segs};

    // Reset state
    rst_n  = 1'b0;
    enable = 1'b0;
    number = 16'h0000;
    dp     = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_a_anodes", an_a, 4'b0000);
    chk("rst_a_seg", seg_a, 7'h00);
    chk("rst_a_dot", dot_a, 1'b0);
    chk("rst_a_frame_start", fs_a, 1'b0);
    chk("rst_c_anodes", an_c, 4'b1111);
    chk("rst_c_seg", seg_c, 7'h7F);
    chk("rst_c_dot", dot_c, 1'b1);

    // Frame 0 shows the cleared snapshot; each later frame shows the vector driven mid-frame before it.
    rst_n  = 1'b1;
    number = 16'hFFFF;
    dp     = 4'b1111;
    enable = 1'b1;
    push_frame(zero_segs, 4'b0000);
    for (int f = 0; f <= NV; f++) begin
      for (int d = 0; d < 4; d++) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got no entry expected one at frame %0d digit %0d", f, d);
        end else begin
          e       = sb_q.pop_front();
          inv_seg = ~e.seg;
          inv_an  = ~e.an;
          inv_dot = ~e.dot;
          chk("a_anodes", an_a, e.an);
          chk("a_seg", seg_a, e.seg);
          chk("a_dot", dot_a, e.dot);
          chk("a_frame_start", fs_a, (d == 3));
          chk("c_anodes", an_c, inv_an);
          chk("c_seg", seg_c, inv_seg);
          chk("c_dot", dot_c, inv_dot);
        end
        if (d == 1 && f < NV) begin
          number = vecs[f].num;
          dp     = vecs[f].dp;
          push_frame(vecs[f].segs, vecs[f].dp);
        end
      end
    end

    // Load a non-zero snapshot, then reset mid-frame: display must restart from snapshot 0.
    number = 16'h8888;
    dp     = 4'b1111;
    repeat (6) @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("midrst_a_anodes", an_a, 4'b0000);
    chk("midrst_a_seg", seg_a, 7'h00);
    chk("midrst_a_frame_start", fs_a, 1'b0);
    chk("midrst_c_anodes", an_c, 4'b1111);
    chk("midrst_c_seg", seg_c, 7'h7F);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    b_run[0] = 4'b0001; b_run[1] = 4'b0001; b_run[2] = 4'b0001;
    b_run[3] = 4'b0010; b_run[4] = 4'b0010;
    b_resume[0] = 4'b0010; b_resume[1] = 4'b0100; b_resume[2] = 4'b0100;
    b_resume[3] = 4'b0100; b_resume[4] = 4'b1000;
    a_after_rst[0] = 7'h3F;
    a_after_rst[1] = LZ ? 7'h00 : 7'h3F;
    a_after_rst[2] = LZ ? 7'h00 : 7'h3F;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_run_anodes", an_b, b_run[i]);
      chk("b_run_dot", dot_b, 1'b0);
      if (i < 3) begin
        chk("a_postrst_anodes", an_a, 4'b0001 << i);
        chk("a_postrst_seg", seg_a, a_after_rst[i]);
        chk("a_postrst_dot", dot_a, 1'b0);
        chk("a_postrst_frame_start", fs_a, 1'b0);
      end
    end

    // Enable low: everything inactive, counters frozen.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_off_anodes", an_b, 4'b0000);
      chk("b_off_seg", seg_b, 7'h00);
      chk("b_off_dot", dot_b, 1'b0);
      chk("a_off_anodes", an_a, 4'b0000);
      chk("c_off_anodes", an_c, 4'b1111);
      chk("c_off_seg", seg_c, 7'h7F);
    end

    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_resume_anodes", an_b, b_resume[i]);
      chk("b_resume_frame_start", fs_b, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
